// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: sequencer state encoding,
// opcode constants and default parameter values.
package cpu_pkg;

  // Instruction-cycle states of the sequencer.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int unsigned OP_W = 4;

  // Opcode map of the instruction set.
  localparam logic [OP_W-1:0] OPC_LDA = 4'd0;
  localparam logic [OP_W-1:0] OPC_STA = 4'd1;
  localparam logic [OP_W-1:0] OPC_ADD = 4'd2;
  localparam logic [OP_W-1:0] OPC_SUB = 4'd3;
  localparam logic [OP_W-1:0] OPC_JMP = 4'd4;
  localparam logic [OP_W-1:0] OPC_JMI = 4'd5;
  localparam logic [OP_W-1:0] OPC_JEQ = 4'd6;
  localparam logic [OP_W-1:0] OPC_STP = 4'd7;
  localparam logic [OP_W-1:0] OPC_LDI = 4'd8;

  // Highest legal opcode; anything above it is illegal.
  localparam logic [OP_W-1:0] OPC_MAX_DEF = OPC_LDI;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between front panel + decoder (master) and the
// instruction-cycle sequencer (slave).
//   master drives: RUN, STEP, CLEAR, EXTRA, IR_OP
//   slave drives : IR_LOAD, FETCH, EXEC1, EXEC2, BUSY, HALTED, ILLEGAL,
//                  CYCLE_CNT, INSTR_CNT
interface cpu_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             RUN;
  logic             STEP;
  logic             CLEAR;
  logic             EXTRA;
  logic [3:0]       IR_OP;

  logic             IR_LOAD;
  logic             FETCH;
  logic             EXEC1;
  logic             EXEC2;
  logic             BUSY;
  logic             HALTED;
  logic             ILLEGAL;
  logic [CNT_W-1:0] CYCLE_CNT;
  logic [CNT_W-1:0] INSTR_CNT;

  modport master (
    output RUN, STEP, CLEAR, EXTRA, IR_OP,
    input  IR_LOAD, FETCH, EXEC1, EXEC2, BUSY, HALTED, ILLEGAL,
           CYCLE_CNT, INSTR_CNT
  );

  modport slave (
    input  RUN, STEP, CLEAR, EXTRA, IR_OP,
    output IR_LOAD, FETCH, EXEC1, EXEC2, BUSY, HALTED, ILLEGAL,
           CYCLE_CNT, INSTR_CNT
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only
// by reset.
//   clk, rst_n : clock, async active-low reset
//   inc        : increment request
//   q          : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: produces one-hot FETCH/EXEC1/EXEC2 strobes,
// handles run/step/halt/clear, flags illegal opcodes and keeps saturating
// debug counters.
//   CLOCK, RESET_N : clock, async active-low reset
//   bus (slave)    : RUN/STEP/CLEAR controls, EXTRA/IR_OP from decode,
//                    phase strobes, status flags and debug counters
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     CNT_W  = CNT_W_DEF,
  parameter logic [OP_W-1:0] OP_STP = OPC_STP,
  parameter logic [OP_W-1:0] OP_MAX = OPC_MAX_DEF
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  cpu_sequencer_if.slave  bus
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   fetch_q, exec1_q, exec2_q, busy_q, halted_q;
  logic   instr_done;
  logic   cycle_inc;

  // Next-state logic; completion also drives the instruction counter.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    instr_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.RUN || bus.STEP) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC1;
      end
      ST_EXEC1: begin
        if (bus.IR_OP > OP_MAX) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (bus.IR_OP == OP_STP) begin
          state_d    = ST_HALT;
          instr_done = 1'b1;
        end else if (bus.EXTRA) begin
          state_d = ST_EXEC2;
        end else begin
          instr_done = 1'b1;
          state_d    = bus.RUN ? ST_FETCH : ST_IDLE;
        end
      end
      ST_EXEC2: begin
        instr_done = 1'b1;
        state_d    = bus.RUN ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        if (bus.CLEAR) begin
          state_d   = ST_IDLE;
          illegal_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every edge leaving a busy phase is one counted cycle.
  assign cycle_inc = (state_q == ST_FETCH) || (state_q == ST_EXEC1) ||
                     (state_q == ST_EXEC2);

  // State register; strobes are registered from the next state so they
  // always match the state held in state_q.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      fetch_q   <= 1'b0;
      exec1_q   <= 1'b0;
      exec2_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      fetch_q   <= (state_d == ST_FETCH);
      exec1_q   <= (state_d == ST_EXEC1);
      exec2_q   <= (state_d == ST_EXEC2);
      busy_q    <= (state_d == ST_FETCH) || (state_d == ST_EXEC1) ||
                   (state_d == ST_EXEC2);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  assign bus.IR_LOAD = fetch_q;
  assign bus.FETCH   = fetch_q;
  assign bus.EXEC1   = exec1_q;
  assign bus.EXEC2   = exec2_q;
  assign bus.BUSY    = busy_q;
  assign bus.HALTED  = halted_q;
  assign bus.ILLEGAL = illegal_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .inc   (cycle_inc),
    .q     (bus.CYCLE_CNT)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .inc   (instr_done),
    .q     (bus.INSTR_CNT)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes the expected per-cycle
// phase/flags/counters, a monitor pops and compares on each falling edge
// (or just after an asynchronous reset assertion).
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int P_IDLE = 0;
  localparam int P_F    = 1;
  localparam int P_E1   = 2;
  localparam int P_E2   = 3;
  localparam int P_HALT = 4;

  typedef struct {
    int sel;
    int ph;
    int ill;
    int cyc;
    int ins;
    int scn;
    int idx;
  } exp_t;

  logic clk;
  logic rst_n;

  cpu_sequencer_if #(.CNT_W(16)) bus0 ();
  cpu_sequencer_if #(.CNT_W(4))  bus1 ();

  cpu_sequencer #(.CNT_W(16)) u_dut0 (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus0)
  );

  cpu_sequencer #(.CNT_W(4)) u_dut1 (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus1)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   scn      = 0;
  int   idx      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Wait for the next active edge and record what the DUT must show this cycle.
  task automatic expc(input int sel, input int ph, input int ill, input int cyc, input int ins);
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = sel; e.ph = ph; e.ill = ill; e.cyc = cyc; e.ins = ins;
    e.scn = scn; e.idx = idx;
    idx++;
    exp_q.push_back(e);
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Monitor: compare one queued expectation per sample point.
  initial begin
    exp_t       e;
    logic [6:0] act_f, exp_f;
    int         act_c, act_i;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 0) begin
          act_f = {bus0.IR_LOAD, bus0.FETCH, bus0.EXEC1, bus0.EXEC2,
                   bus0.BUSY, bus0.HALTED, bus0.ILLEGAL};
          act_c = int'(bus0.CYCLE_CNT);
          act_i = int'(bus0.INSTR_CNT);
        end else begin
          act_f = {bus1.IR_LOAD, bus1.FETCH, bus1.EXEC1, bus1.EXEC2,
                   bus1.BUSY, bus1.HALTED, bus1.ILLEGAL};
          act_c = int'(bus1.CYCLE_CNT);
          act_i = int'(bus1.INSTR_CNT);
        end
        exp_f = {e.ph == P_F, e.ph == P_F, e.ph == P_E1, e.ph == P_E2,
                 (e.ph == P_F) || (e.ph == P_E1) || (e.ph == P_E2),
                 e.ph == P_HALT, e.ill != 0};
        n_checks++;
        if ((act_f === exp_f) && (act_c == e.cyc) && (act_i == e.ins)) begin
          n_pass++;
        end else begin
          $display("FAIL s%0d.c%0d dut%0d: got ld/f/e1/e2/busy/halt/ill=%b cyc=%0d ins=%0d, need %b cyc=%0d ins=%0d",
                   e.scn, e.idx, e.sel, act_f, act_c, act_i, exp_f, e.cyc, e.ins);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus0.RUN = 0; bus0.STEP = 0; bus0.CLEAR = 0; bus0.EXTRA = 0; bus0.IR_OP = '0;
    bus1.RUN = 0; bus1.STEP = 0; bus1.CLEAR = 0; bus1.EXTRA = 0; bus1.IR_OP = '0;

    // Reset values, then IDLE holds with RUN=0.
    scn = 1;
    expc(0, P_IDLE, 0, 0, 0);
    expc(0, P_IDLE, 0, 0, 0);
    rst_n = 1'b1;
    expc(0, P_IDLE, 0, 0, 0);
    expc(0, P_IDLE, 0, 0, 0);

    // RUN: LDA (EXTRA), STA, STP -> halt; HALT ignores RUN/STEP; CLEAR.
    scn = 2;
    bus0.RUN = 1;
    expc(0, P_F,  0, 0, 0);
    expc(0, P_E1, 0, 1, 0); bus0.IR_OP = OPC_LDA; bus0.EXTRA = 1;
    expc(0, P_E2, 0, 2, 0);
    expc(0, P_F,  0, 3, 1);
    expc(0, P_E1, 0, 4, 1); bus0.IR_OP = OPC_STA; bus0.EXTRA = 0;
    expc(0, P_F,  0, 5, 2);
    expc(0, P_E1, 0, 6, 2); bus0.IR_OP = OPC_STP;
    expc(0, P_HALT, 0, 7, 3); bus0.STEP = 1;
    expc(0, P_HALT, 0, 7, 3); bus0.STEP = 0; bus0.CLEAR = 1; bus0.RUN = 0;
    expc(0, P_IDLE, 0, 7, 3); bus0.CLEAR = 0;

    // STEP with ADD (EXTRA); a STEP during EXEC1 is dropped.
    scn = 3;
    bus0.STEP = 1;
    expc(0, P_F,  0, 7, 3); bus0.STEP = 0;
    expc(0, P_E1, 0, 8, 3); bus0.IR_OP = OPC_ADD; bus0.EXTRA = 1; bus0.STEP = 1;
    expc(0, P_E2, 0, 9, 3); bus0.STEP = 0;
    expc(0, P_IDLE, 0, 10, 4);
    expc(0, P_IDLE, 0, 10, 4);

    // Illegal opcode 0xC halts uncounted; CLEAR recovers; LDI is legal.
    scn = 4;
    bus0.STEP = 1;
    expc(0, P_F,  0, 10, 4); bus0.STEP = 0;
    expc(0, P_E1, 0, 11, 4); bus0.IR_OP = 4'hC; bus0.EXTRA = 0;
    expc(0, P_HALT, 1, 12, 4);
    expc(0, P_HALT, 1, 12, 4); bus0.CLEAR = 1;
    expc(0, P_IDLE, 0, 12, 4); bus0.CLEAR = 0;
    expc(0, P_IDLE, 0, 12, 4); bus0.STEP = 1;
    expc(0, P_F,  0, 12, 4); bus0.STEP = 0;
    expc(0, P_E1, 0, 13, 4); bus0.IR_OP = OPC_LDI; bus0.EXTRA = 0;
    expc(0, P_IDLE, 0, 14, 5);

    // RUN dropped in EXEC1 of SUB (EXTRA): EXEC2 still runs, then IDLE.
    scn = 5;
    bus0.RUN = 1;
    expc(0, P_F,  0, 14, 5);
    expc(0, P_E1, 0, 15, 5); bus0.IR_OP = OPC_SUB; bus0.EXTRA = 1; bus0.RUN = 0;
    expc(0, P_E2, 0, 16, 5);
    expc(0, P_IDLE, 0, 17, 6);
    expc(0, P_IDLE, 0, 17, 6);

    // RUN+STEP together acts as RUN (no bubble); async reset in EXEC2.
    scn = 6;
    bus0.RUN = 1; bus0.STEP = 1;
    expc(0, P_F,  0, 17, 6); bus0.STEP = 0;
    expc(0, P_E1, 0, 18, 6); bus0.IR_OP = OPC_JMP; bus0.EXTRA = 0;
    expc(0, P_F,  0, 19, 7);
    expc(0, P_E1, 0, 20, 7); bus0.IR_OP = OPC_LDA; bus0.EXTRA = 1;
    expc(0, P_E2, 0, 21, 7);
    @(negedge clk);
    #3;
    begin
      exp_t e;
      e.sel = 0; e.ph = P_IDLE; e.ill = 0; e.cyc = 0; e.ins = 0;
      e.scn = scn; e.idx = idx;
      idx++;
      exp_q.push_back(e);
    end
    rst_n = 1'b0;
    bus0.RUN = 0;
    expc(0, P_IDLE, 0, 0, 0);
    rst_n = 1'b1;
    expc(0, P_IDLE, 0, 0, 0);
    expc(0, P_IDLE, 0, 0, 0);

    // 4-bit counters: 20 JMPs under RUN saturate both at 15.
    scn = 7;
    bus1.RUN = 1;
    for (int i = 0; i < 20; i++) begin
      expc(1, P_F,  0, sat15(2 * i), sat15(i));
      expc(1, P_E1, 0, sat15(2 * i + 1), sat15(i));
      bus1.IR_OP = OPC_JMP; bus1.EXTRA = 0;
      if (i == 19) bus1.RUN = 0;
    end
    expc(1, P_IDLE, 0, 15, 15);
    expc(1, P_IDLE, 0, 15, 15);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle controller for the accumulator CPU. Generates the one-hot FETCH/EXEC1/EXEC2 phase strobes consumed by the instruction decoder, using the decoder's EXTRA output to choose between two-phase and three-phase instructions. Provides run, single-step and halt control, flags illegal opcodes, and keeps saturating cycle and instruction counters for debug. Sits between the front-panel/debug controls and the decode/datapath.

## Interface
- CNT_W, 16: width of both debug counters.
- OP_STP, 4'b0111: opcode that halts the machine.
- OP_MAX, 4'd8: highest legal opcode (LDI). Opcodes above this are illegal.

- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RUN  in  1  level. While high, instructions execute back-to-back.
- STEP  in  1  single-cycle pulse. Executes exactly one instruction from IDLE.
- CLEAR  in  1  single-cycle pulse. Leaves HALT and clears the HALTED and ILLEGAL flags.
- EXTRA  in  1  from decode. The instruction needs EXEC2. Sampled only in EXEC1.
- IR_OP  in  4  current IR opcode. Valid from EXEC1 onward.
- IR_LOAD  out  1  load IR from memory. Equal to FETCH.
- FETCH, EXEC1, EXEC2  out  1 each  phase strobes. At most one is high at a time.
- BUSY  out  1  state is FETCH, EXEC1 or EXEC2.
- HALTED  out  1  state is HALT.
- ILLEGAL  out  1  sticky flag: the machine halted on an illegal opcode.
- CYCLE_CNT  out  CNT_W  count of cycles spent in FETCH, EXEC1 or EXEC2. Saturating.
- INSTR_CNT  out  CNT_W  count of completed instructions. Saturating.

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, HALT. All outputs are Moore outputs decoded from the registered state and flags.
- Reset state:
  - State is IDLE.
  - All strobes, BUSY, HALTED and ILLEGAL are 0.
  - Both counters are 0.
- IDLE:
  - Goes to FETCH if RUN=1 or STEP=1.
  - Otherwise holds.
  - CLEAR has no effect here.
- FETCH always goes to EXEC1.
- EXEC1 checks in this priority order:
  - IR_OP > OP_MAX: go to HALT and set ILLEGAL. The instruction is not counted.
  - IR_OP == OP_STP: go to HALT. The instruction is counted.
  - EXTRA=1: go to EXEC2.
  - Otherwise the instruction completes (see below).
- EXEC2: the instruction always completes.
- On completion:
  - INSTR_CNT increments.
  - Next state is FETCH if RUN=1, otherwise IDLE.
- STEP is sampled only in IDLE. A STEP pulse arriving in any other state is dropped and is not queued.
- RUN is sampled only in IDLE and at completion. Dropping RUN mid-instruction lets the current instruction finish, then the machine goes to IDLE.
- HALT holds regardless of RUN and STEP.
  - CLEAR=1 moves to IDLE next cycle and zeroes HALTED and ILLEGAL.
  - Counters are retained.
- Counters saturate at 2^CNT_W−1 and never wrap. Only reset zeroes them.
- Simultaneous RUN and STEP in IDLE behaves as RUN.

## Timing
- RUN or STEP high at edge k in IDLE: FETCH is high during cycle k+1.
- An instruction without EXTRA takes 2 cycles (FETCH, EXEC1). An instruction with EXTRA takes 3 cycles (FETCH, EXEC1, EXEC2).
- Under RUN there is no bubble: the cycle after completion is FETCH.
- INSTR_CNT updates at the edge that leaves the completing phase, so the new value is visible in the next cycle.
- CYCLE_CNT increments at each edge that leaves a BUSY state.
- An assertion of RESET_N low in any state forces reset values immediately, without waiting for a clock edge. The first FETCH after reset release requires RUN or STEP.
- HALTED is high from the cycle after the halting EXEC1 until the cycle after CLEAR.

## Structure
- Shared package cpu_pkg holds:
  - the state enum;
  - the opcode constants LDA=0, STA=1, ADD=2, SUB=3, JMP=4, JMI=5, JEQ=6, STP=7, LDI=8;
  - the OP_MAX default.
- One sub-module, sat_counter (parameter W; ports inc, q), instantiated twice, once per debug counter.
- The state register and next-state logic live in cpu_sequencer.

## Test plan
- Reset during EXEC2 of an LDA → all strobes, flags and counters are 0 immediately. The machine stays in IDLE after release while RUN=0.
- RUN=1 with program LDA (EXTRA=1), STA (EXTRA=0), STP → phases F,E1,E2,F,E1,F,E1 then HALT. Final values: INSTR_CNT=3, CYCLE_CNT=7, HALTED=1.
- STEP pulse in IDLE with ADD (EXTRA=1) → F,E1,E2 then IDLE, and INSTR_CNT=1. A second STEP pulsed during EXEC1 is ignored, so the machine stays in IDLE afterwards.
- IR_OP=4'hC in EXEC1 → HALT with ILLEGAL=1 and INSTR_CNT unchanged. CLEAR → IDLE with HALTED=0 and ILLEGAL=0, counters unchanged.
- RUN dropped during EXEC1 of a SUB (EXTRA=1) → EXEC2 still occurs, then IDLE, and INSTR_CNT increments by 1.
- CNT_W=4, RUN with 20 JMP instructions → INSTR_CNT=15 and CYCLE_CNT=15, both saturated with no wrap.
